// File: rtl/game_step_scheduler.sv
// Purpose : paces snake moves, judges each move (die / eat / continue), runs
//           the eat-score-level sequence and the target-request handshake.
// Latency : SHIFT fires after (BASE_PERIOD - LEVEL*PERIOD_STEP) WAIT cycles;
//           all outputs are registered and change one edge after the cause.
// Backpressure: SHIFT_DONE (bounded by DONE_TIMEOUT) and TARGET_ACK stall the
//           sequence; leaving PLAY aborts back to WAIT except from HALT.
//
// Ports:
//   CLK, RESET       clock, synchronous active-low reset
//   M_STATE          master state, 2'b01 = PLAY
//   SHIFT_DONE       pulse: snake body shift finished
//   COLLIDE, REACHED levels sampled once in CHECK (COLLIDE wins)
//   TARGET_ACK       pulse: new target latched (only honoured in TGT_WAIT)
//   SHIFT            one-cycle move strobe
//   TARGET_REQ       level request for a new target
//   SCORE_EN         one-cycle score increment
//   LEVEL            speed level, saturates at MAX_LEVEL
//   DEAD             sticky collision flag, cleared only by reset
//   BUSY             high outside WAIT and HALT
module game_step_scheduler #(
    parameter int unsigned BASE_PERIOD  = 25000000,
    parameter int unsigned PERIOD_STEP  = 2500000,
    parameter int unsigned MAX_LEVEL    = 7,
    parameter int unsigned DONE_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] M_STATE,
    input  logic       SHIFT_DONE,
    input  logic       COLLIDE,
    input  logic       REACHED,
    input  logic       TARGET_ACK,
    output logic       SHIFT,
    output logic       TARGET_REQ,
    output logic       SCORE_EN,
    output logic [2:0] LEVEL,
    output logic       DEAD,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_SHIFT,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_EAT,
        ST_TGT_WAIT,
        ST_HALT
    } state_t;

    localparam logic [1:0]  PLAY      = 2'b01;
    localparam logic [2:0]  LEVEL_MAX = 3'(MAX_LEVEL);
    // done_cnt is 0 in the SHIFT cycle, so this value exits WAIT_DONE exactly
    // DONE_TIMEOUT cycles after the SHIFT strobe.
    localparam logic [31:0] DONE_LAST = 32'(DONE_TIMEOUT - 1);

    state_t      state;
    logic [31:0] period_cnt;
    logic [31:0] done_cnt;
    logic [31:0] period;
    logic [31:0] period_last;
    logic [1:0]  eat_cnt;
    logic        play;

    assign play        = (M_STATE == PLAY);
    assign period      = 32'(BASE_PERIOD) - 32'(LEVEL) * 32'(PERIOD_STEP);
    assign period_last = period - 32'd1;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= ST_WAIT;
            period_cnt <= 32'd0;
            done_cnt   <= 32'd0;
            eat_cnt    <= 2'd0;
            LEVEL      <= 3'd0;
            SHIFT      <= 1'b0;
            TARGET_REQ <= 1'b0;
            SCORE_EN   <= 1'b0;
            DEAD       <= 1'b0;
            BUSY       <= 1'b0;
        end else if (state != ST_HALT && !play) begin
            // Leaving PLAY beats everything else, including a terminal count
            // in WAIT; LEVEL and eat_cnt are deliberately left alone.
            state      <= ST_WAIT;
            period_cnt <= 32'd0;
            SHIFT      <= 1'b0;
            TARGET_REQ <= 1'b0;
            SCORE_EN   <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            // Strobes are only raised on the edge entering their state.
            SHIFT    <= 1'b0;
            SCORE_EN <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (period_cnt >= period_last) begin
                        state      <= ST_SHIFT;
                        period_cnt <= 32'd0;
                        done_cnt   <= 32'd0;
                        SHIFT      <= 1'b1;
                        BUSY       <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + 32'd1;
                    end
                end
                ST_SHIFT: begin
                    state    <= ST_WAIT_DONE;
                    done_cnt <= done_cnt + 32'd1;
                end
                ST_WAIT_DONE: begin
                    if (SHIFT_DONE || done_cnt >= DONE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        done_cnt <= done_cnt + 32'd1;
                    end
                end
                ST_CHECK: begin
                    if (COLLIDE) begin
                        state <= ST_HALT;
                        DEAD  <= 1'b1;
                        BUSY  <= 1'b0;
                    end else if (REACHED) begin
                        state    <= ST_EAT;
                        SCORE_EN <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                        BUSY  <= 1'b0;
                    end
                end
                ST_EAT: begin
                    eat_cnt <= eat_cnt + 2'd1;
                    // Every fourth eat (eat_cnt wrapping 3->0) speeds up.
                    if (eat_cnt == 2'd3 && LEVEL < LEVEL_MAX) begin
                        LEVEL <= LEVEL + 3'd1;
                    end
                    state      <= ST_TGT_WAIT;
                    TARGET_REQ <= 1'b1;
                end
                ST_TGT_WAIT: begin
                    if (TARGET_ACK) begin
                        state      <= ST_WAIT;
                        TARGET_REQ <= 1'b0;
                        BUSY       <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_WAIT;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_step_scheduler.sv
// Purpose : self-checking bench for game_step_scheduler (directed + random).
// Latency : a reference model steps on every rising edge; outputs compared 1 time unit later.
// Backpressure: the bench plays snake logic / target generator and drives all handshakes.
module tb_game_step_scheduler;

    localparam int BP = 10;
    localparam int PS = 2;
    localparam int ML = 4;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] m_state = 2'b01;
    logic       shift_done = 1'b0;
    logic       collide = 1'b0;
    logic       reached = 1'b0;
    logic       target_ack = 1'b0;
    logic       shift;
    logic       target_req;
    logic       score_en;
    logic [2:0] level;
    logic       dead;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;
    int n_shift = 0;
    int n_score = 0;

    game_step_scheduler #(
        .BASE_PERIOD (BP),
        .PERIOD_STEP (PS),
        .MAX_LEVEL   (ML),
        .DONE_TIMEOUT(TO)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .M_STATE   (m_state),
        .SHIFT_DONE(shift_done),
        .COLLIDE   (collide),
        .REACHED   (reached),
        .TARGET_ACK(target_ack),
        .SHIFT     (shift),
        .TARGET_REQ(target_req),
        .SCORE_EN  (score_en),
        .LEVEL     (level),
        .DEAD      (dead),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Phase of the game plus plain counters; level is derived from total eats.
    typedef enum int {P_IDLE, P_MOVE, P_SETTLE, P_JUDGE, P_SCORE, P_FETCH, P_OVER} phase_t;
    phase_t mdl_phase = P_IDLE;
    int     mdl_elapsed = 0;
    int     mdl_since = 0;
    int     mdl_eats = 0;

    function automatic int mdl_level();
        return (mdl_eats / 4 > ML) ? ML : mdl_eats / 4;
    endfunction

    task automatic model_step();
        if (!reset) begin
            mdl_phase = P_IDLE; mdl_elapsed = 0; mdl_eats = 0;
        end else if (mdl_phase != P_OVER && m_state != 2'b01) begin
            mdl_phase = P_IDLE; mdl_elapsed = 0;
        end else begin
            case (mdl_phase)
                P_IDLE: begin
                    mdl_elapsed++;
                    if (mdl_elapsed == BP - mdl_level() * PS) begin
                        mdl_phase = P_MOVE; mdl_elapsed = 0;
                    end
                end
                P_MOVE:   begin mdl_phase = P_SETTLE; mdl_since = 1; end
                P_SETTLE: if (shift_done || mdl_since == TO - 1) mdl_phase = P_JUDGE;
                          else mdl_since++;
                P_JUDGE:  if (collide) mdl_phase = P_OVER;
                          else if (reached) mdl_phase = P_SCORE;
                          else mdl_phase = P_IDLE;
                P_SCORE:  begin mdl_eats++; mdl_phase = P_FETCH; end
                P_FETCH:  if (target_ack) mdl_phase = P_IDLE;
                default:  ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        chk("m_shift",      shift,      mdl_phase == P_MOVE);
        chk("m_score_en",   score_en,   mdl_phase == P_SCORE);
        chk("m_target_req", target_req, mdl_phase == P_FETCH);
        chk("m_dead",       dead,       mdl_phase == P_OVER);
        chk("m_busy",       busy,       mdl_phase != P_IDLE && mdl_phase != P_OVER);
        chk("m_level",      level,      mdl_level());
    end

    always @(negedge clk) begin
        if (shift === 1'b1) n_shift++;
        if (score_en === 1'b1) n_score++;
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Advance until SHIFT is high; idle counts cycles seen with BUSY low.
    task automatic wait_shift(output int idle, output int cyc);
        idle = 0; cyc = 0;
        while (shift !== 1'b1) begin
            if (busy === 1'b0) idle++;
            tick(); cyc++;
            if (cyc > 300) begin
                chk("shift_timeout", shift, 1);
                return;
            end
        end
    endtask

    // Called in a SHIFT cycle: completes the move, eats, acks after gap cycles.
    task automatic eat_once(input int gap);
        int reqc;
        reqc = 0;
        tick(); shift_done = 1'b1; reached = 1'b1;
        tick(); shift_done = 1'b0;
        tick(); reached = 1'b0;
        chk("eat_score_en", score_en, 1);
        tick();
        for (int i = 0; i < gap; i++) begin
            reqc += int'(target_req); tick();
        end
        target_ack = 1'b1; reqc += int'(target_req);
        tick(); target_ack = 1'b0;
        chk("req_high_cycles", reqc, gap + 1);
        chk("req_drop_after_ack", target_req, 0);
    endtask

    initial begin
        int idle, cyc, n, s0, sh0, e;

        reset = 1'b0; m_state = 2'b01;
        tick(); tick();
        chk("rst_shift", shift, 0);
        chk("rst_req", target_req, 0);
        chk("rst_score", score_en, 0);
        chk("rst_level", level, 0);
        chk("rst_dead", dead, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;

        // steady moves at level 0
        wait_shift(idle, cyc);
        chk("period_l0", idle, 10);
        for (int k = 0; k < 3; k++) begin
            tick(); shift_done = 1'b1;
            tick(); shift_done = 1'b0;
            wait_shift(idle, cyc);
            chk("shift_interval", cyc + 2, 13);
            chk("alive", dead, 0);
        end

        // four eats -> level 1, period 8
        s0 = n_score;
        for (int k = 0; k < 4; k++) begin
            eat_once(5);
            chk("level_after_eat", level, (k + 1) / 4);
            wait_shift(idle, cyc);
        end
        chk("score_pulses_4", n_score - s0, 4);
        chk("level_1", level, 1);
        chk("period_l1", idle, 8);

        // no SHIFT_DONE: CHECK 15 cycles after SHIFT, so SCORE_EN at +16
        n = 0; reached = 1'b1;
        do begin tick(); n++; end while (score_en !== 1'b1 && n < 40);
        chk("timeout_eat_at_16", n, 16);
        reached = 1'b0;
        tick();
        chk("tgt_req_up", target_req, 1);

        // leave PLAY inside TGT_WAIT
        tick(); tick();
        m_state = 2'b00;
        tick();
        chk("pause_req_drop", target_req, 0);
        chk("pause_busy", busy, 0);
        chk("pause_level", level, 1);
        sh0 = n_shift;
        for (int i = 0; i < 20; i++) begin
            target_ack = (i == 5); tick();
        end
        target_ack = 1'b0;
        chk("no_shift_paused", n_shift - sh0, 0);

        // leave PLAY exactly at terminal count
        m_state = 2'b01;
        for (int i = 0; i < 7; i++) tick();
        m_state = 2'b00;
        tick();
        chk("tc_leave_no_shift", shift, 0);
        chk("tc_leave_busy", busy, 0);
        m_state = 2'b01;
        wait_shift(idle, cyc);
        chk("period_after_pause", idle, 8);

        // climb to level 3 (12 eats total)
        for (int k = 0; k < 7; k++) begin
            eat_once(1 + k % 4);
            wait_shift(idle, cyc);
        end
        chk("level_3", level, 3);

        // reset in the middle of TGT_WAIT
        tick(); shift_done = 1'b1; reached = 1'b1;
        tick(); shift_done = 1'b0;
        tick(); reached = 1'b0;
        tick(); tick(); tick();
        chk("mid_tgt_req", target_req, 1);
        chk("mid_tgt_level", level, 3);
        reset = 1'b0;
        tick();
        chk("r24_shift", shift, 0);
        chk("r24_req", target_req, 0);
        chk("r24_score", score_en, 0);
        chk("r24_level", level, 0);
        chk("r24_dead", dead, 0);
        chk("r24_busy", busy, 0);
        reset = 1'b1;

        // collide and reach together
        wait_shift(idle, cyc);
        tick(); shift_done = 1'b1; collide = 1'b1; reached = 1'b1;
        tick(); shift_done = 1'b0;
        tick(); collide = 1'b0; reached = 1'b0;
        chk("halt_dead", dead, 1);
        chk("halt_no_score", score_en, 0);
        chk("halt_busy", busy, 0);
        sh0 = n_shift; s0 = n_score;
        for (int i = 0; i < 60; i++) begin
            m_state = (i % 10 == 3) ? 2'b00 : 2'b01;
            target_ack = (i % 7 == 2);
            tick();
        end
        m_state = 2'b01; target_ack = 1'b0;
        chk("halt_no_shift", n_shift - sh0, 0);
        chk("halt_no_score_cnt", n_score - s0, 0);
        chk("halt_still_dead", dead, 1);
        reset = 1'b0;
        tick();
        chk("halt_reset_dead", dead, 0);
        reset = 1'b1;

        // level saturation
        for (int k = 0; k < 21; k++) begin
            wait_shift(idle, cyc);
            eat_once(2);
            e = ((k + 1) / 4 > ML) ? ML : (k + 1) / 4;
            chk("sat_level", level, e);
        end

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 399) != 0);
            if (dead === 1'b1 && $urandom_range(0, 7) == 0) reset = 1'b0;
            m_state    = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            shift_done = ($urandom_range(0, 3) == 0);
            collide    = ($urandom_range(0, 29) == 0);
            reached    = ($urandom_range(0, 1) == 1);
            target_ack = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1'b1; m_state = 2'b01;
        shift_done = 1'b0; collide = 1'b0; reached = 1'b0; target_ack = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_step_scheduler.md
GAME_STEP_SCHEDULER -- requirements
Module: game_step_scheduler

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- BASE_PERIOD, 25000000, clock cycles between move steps at level 0.
- PERIOD_STEP, 2500000, period reduction per level.
- MAX_LEVEL, 7, saturating level limit (3-bit).
- DONE_TIMEOUT, 15, maximum cycles to wait for SHIFT_DONE.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- CLK, in, 1, system clock (the only clock).
- RESET, in, 1, synchronous, active-low reset.
- M_STATE, in, 2, master state; 2'b01 = PLAY, all other values = not playing.
- SHIFT_DONE, in, 1, one-cycle pulse from snake logic: body shift complete.
- COLLIDE, in, 1, level; head overlaps wall or body.
- REACHED, in, 1, level; head on target.
- TARGET_ACK, in, 1, one-cycle pulse from target generator: new target latched.
- SHIFT, out, 1, one-cycle move strobe to snake logic.
- TARGET_REQ, out, 1, level request for a new target.
- SCORE_EN, out, 1, one-cycle score increment pulse.
- LEVEL, out, 3, current speed level.
- DEAD, out, 1, level; collision detected.
- BUSY, out, 1, high in every state except WAIT and HALT.

Function
REQ-003 FSM states SHALL be WAIT, SHIFT, WAIT_DONE, CHECK, EAT, TGT_WAIT and HALT.
REQ-004 The period counter SHALL count only in WAIT while M_STATE==PLAY, and SHALL otherwise hold at 0.
REQ-005 Period SHALL equal BASE_PERIOD - LEVEL*PERIOD_STEP. When the counter reaches period-1, the FSM SHALL go to SHIFT and the counter SHALL clear to 0.
REQ-006 SHIFT SHALL be high for exactly the one cycle the FSM spends in SHIFT; the next state SHALL be WAIT_DONE.
REQ-007 WAIT_DONE SHALL exit to CHECK on SHIFT_DONE, or after DONE_TIMEOUT cycles without SHIFT_DONE.
REQ-008 CHECK SHALL sample COLLIDE and REACHED once and branch:
- COLLIDE=1: go to HALT and set DEAD=1. COLLIDE SHALL have priority over REACHED.
- REACHED=1 only: go to EAT.
- Neither: go to WAIT.
REQ-009 EAT SHALL last one cycle and SHALL pulse SCORE_EN. It SHALL increment a 2-bit eat counter.
REQ-010 When the eat counter wraps from 3 to 0, LEVEL SHALL increment, saturating at MAX_LEVEL. EAT SHALL then go to TGT_WAIT.
REQ-011 TARGET_REQ SHALL rise on entry to TGT_WAIT and stay high until the cycle after TARGET_ACK, when the FSM SHALL return to WAIT.
REQ-012 A TARGET_ACK arriving outside TGT_WAIT SHALL be ignored.
REQ-013 In HALT, SHIFT, SCORE_EN and TARGET_REQ SHALL stay 0. HALT SHALL be left only by reset.
REQ-014 If M_STATE leaves PLAY in any state other than HALT, the FSM SHALL go to WAIT on the next cycle, drop TARGET_REQ and suppress any pending SHIFT or SCORE_EN. LEVEL and the eat counter SHALL hold.
REQ-015 If M_STATE leaves PLAY in the same cycle the counter reaches terminal count, leaving PLAY SHALL win and no SHIFT SHALL occur.
REQ-016 The period arithmetic SHALL use 32-bit unsigned values. The parameters SHALL guarantee a period of at least 2 at MAX_LEVEL.

Reset
REQ-017 On a clock edge with RESET=0, the block SHALL reset to:
- FSM = WAIT, period counter = 0, eat counter = 0, LEVEL = 0.
- SHIFT = 0, TARGET_REQ = 0, SCORE_EN = 0, DEAD = 0, BUSY = 0.
REQ-018 Reset SHALL take effect from any state, including mid-handshake in TGT_WAIT.

Verification
All scenarios use BASE_PERIOD=10, PERIOD_STEP=2, DONE_TIMEOUT=15.
REQ-019 Release reset, hold M_STATE=01, pulse SHIFT_DONE one cycle after each SHIFT -> SHIFT pulses exactly once every 10+3 cycles at LEVEL 0, and DEAD=0.
REQ-020 Hold REACHED=1 in CHECK, pulse TARGET_ACK 5 cycles later, repeat 4 times -> 4 SCORE_EN pulses, TARGET_REQ high 6 cycles each time, LEVEL goes to 1, and the next period is 8.
REQ-021 Assert COLLIDE and REACHED together at CHECK -> DEAD=1, no SCORE_EN, and no further SHIFT until RESET=0.
REQ-022 Never pulse SHIFT_DONE -> CHECK is entered 15 cycles after SHIFT.
REQ-023 Set M_STATE=00 while in TGT_WAIT -> TARGET_REQ drops the next cycle, state returns to WAIT, counter holds 0, and LEVEL is unchanged.
REQ-024 Assert RESET=0 mid-TGT_WAIT at LEVEL 3 -> all outputs reach their REQ-017 values on that edge.
